paint_stroke_engine: RTL and testbench

Converts the stream of cursor positions from the mouse-tracking logic into VGA pixel writes for the paint canvas. Consecutive pen-down positions are joined by a Bresenham line, and a square brush is stamped at every line point, so fast mouse motion leaves no gaps. It sits between the cursor-position register and the vga_adapter write port, and replaces the fixed 5x5 stamp loop.

---
 rtl/paint_stroke_engine_if.sv | 31 +++
 rtl/paint_stroke_engine.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_paint_stroke_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/paint_stroke_engine_if.sv
// paint_stroke_engine_if
//   Groups the cursor-side inputs and the vga_adapter-side outputs of the
//   paint stroke engine.
//   master : cursor/mouse logic side (drives cursor_*, pen_*, observes vga_*)
//   slave  : the engine itself
//   Signals:
//     cursor_x[8:0], cursor_y[7:0], cursor_valid, pen_down, pen_color[8:0]
//     vga_x[8:0], vga_y[7:0], vga_color[8:0], vga_write, busy, coalesced
interface paint_stroke_engine_if;
   logic [8:0] cursor_x;
   logic [7:0] cursor_y;
   logic       cursor_valid;
   logic       pen_down;
   logic [8:0] pen_color;
   logic [8:0] vga_x;
   logic [7:0] vga_y;
   logic [8:0] vga_color;
   logic       vga_write;
   logic       busy;
   logic       coalesced;

   modport master (
      output cursor_x, cursor_y, cursor_valid, pen_down, pen_color,
      input  vga_x, vga_y, vga_color, vga_write, busy, coalesced
   );

   modport slave (
      input  cursor_x, cursor_y, cursor_valid, pen_down, pen_color,
      output vga_x, vga_y, vga_color, vga_write, busy, coalesced
   );
endinterface

// File: rtl/paint_stroke_engine.sv
// paint_stroke_engine
//   Turns cursor positions into VGA pixel writes. Consecutive pen-down points
//   are joined with a Bresenham line and a BRUSH_SIZE x BRUSH_SIZE square is
//   stamped (row-major, x fastest) at every line point, clipped to the screen.
//   A one-entry pending slot buffers the newest cursor point (latest wins).
//
//   Ports:
//     CLOCK_50 : system clock
//     reset    : synchronous, active-high
//     bus      : paint_stroke_engine_if.slave (cursor in, pixel writes out)
//
//   Build option:
//     PAINT_STROKE_INTERP_EN defined   -> lines drawn from the previous point
//     PAINT_STROKE_INTERP_EN undefined -> only the new point is stamped
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for the pending slot; pops it when full
//   LOAD     | popped point: track pen-up point, or set up line + brush
//   STAMP    | one brush pixel per cycle at the current line point
//   ADVANCE  | segment done -> IDLE, else one Bresenham step -> STAMP
module paint_stroke_engine #(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240,
   parameter int BRUSH_SIZE    = 5
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   paint_stroke_engine_if.slave  bus
);

`ifdef PAINT_STROKE_INTERP_EN
   localparam bit INTERP_EN = 1'b1;
`else
   localparam bit INTERP_EN = 1'b0;
`endif

   localparam logic signed [10:0] HALF  = 11'(BRUSH_SIZE / 2);
   localparam logic signed [10:0] SCR_W = 11'(SCREEN_WIDTH);
   localparam logic signed [10:0] SCR_H = 11'(SCREEN_HEIGHT);
   localparam logic [2:0]         BMAX  = 3'(BRUSH_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STAMP,
      ST_ADVANCE
   } state_t;

   state_t state_q, state_d;

   // pending slot
   logic [8:0] pend_x_q, pend_x_d;
   logic [7:0] pend_y_q, pend_y_d;
   logic       pend_pen_q, pend_pen_d;
   logic [8:0] pend_color_q, pend_color_d;
   logic       pend_full_q, pend_full_d;

   // popped point; also serves as the line end point
   logic [8:0] pt_x_q, pt_x_d;
   logic [7:0] pt_y_q, pt_y_d;
   logic       pt_pen_q, pt_pen_d;
   logic [8:0] color_q, color_d;

   // last consumed point
   logic [8:0] prev_x_q, prev_x_d;
   logic [7:0] prev_y_q, prev_y_d;
   logic       prev_valid_q, prev_valid_d;

   // line walker
   logic [8:0]         cx_q, cx_d;
   logic [7:0]         cy_q, cy_d;
   logic [9:0]         dx_q, dx_d;
   logic signed [9:0]  dy_q, dy_d;
   logic               sx_neg_q, sx_neg_d;
   logic               sy_neg_q, sy_neg_d;
   logic signed [10:0] err_q, err_d;
   logic [2:0]         ox_q, ox_d;
   logic [2:0]         oy_q, oy_d;

   // registered outputs
   logic [8:0] vga_x_q, vga_x_d;
   logic [7:0] vga_y_q, vga_y_d;
   logic [8:0] vga_color_q, vga_color_d;
   logic       vga_write_q, vga_write_d;
   logic       busy_q, busy_d;
   logic       coalesced_q, coalesced_d;

   logic               pop;
   logic [8:0]         start_x;
   logic [7:0]         start_y;
   logic [9:0]         adx, ady;
   logic signed [10:0] px, py;
   logic signed [11:0] e2, dx12, dy12;
   logic signed [10:0] err_n;

   always_comb begin
      state_d      = state_q;
      pend_x_d     = pend_x_q;
      pend_y_d     = pend_y_q;
      pend_pen_d   = pend_pen_q;
      pend_color_d = pend_color_q;
      pend_full_d  = pend_full_q;
      pt_x_d       = pt_x_q;
      pt_y_d       = pt_y_q;
      pt_pen_d     = pt_pen_q;
      color_d      = color_q;
      prev_x_d     = prev_x_q;
      prev_y_d     = prev_y_q;
      prev_valid_d = prev_valid_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      dx_d         = dx_q;
      dy_d         = dy_q;
      sx_neg_d     = sx_neg_q;
      sy_neg_d     = sy_neg_q;
      err_d        = err_q;
      ox_d         = ox_q;
      oy_d         = oy_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_color_d  = vga_color_q;
      vga_write_d  = 1'b0;
      pop          = 1'b0;
      err_n        = err_q;

      // line start: previous point when interpolating from a valid prev,
      // otherwise the new point itself (single-point segment)
      if (INTERP_EN && prev_valid_q) begin
         start_x = prev_x_q;
         start_y = prev_y_q;
      end else begin
         start_x = pt_x_q;
         start_y = pt_y_q;
      end
      adx = (start_x > pt_x_q) ? {1'b0, start_x - pt_x_q} : {1'b0, pt_x_q - start_x};
      ady = (start_y > pt_y_q) ? {2'b00, start_y - pt_y_q} : {2'b00, pt_y_q - start_y};

      px = $signed({2'b00, cx_q}) + $signed({8'b0, ox_q}) - HALF;
      py = $signed({3'b000, cy_q}) + $signed({8'b0, oy_q}) - HALF;

      e2   = {err_q, 1'b0};
      dx12 = {2'b00, dx_q};
      dy12 = {{2{dy_q[9]}}, dy_q};

      case (state_q)
         ST_IDLE: begin
            if (pend_full_q) begin
               pop      = 1'b1;
               pt_x_d   = pend_x_q;
               pt_y_d   = pend_y_q;
               pt_pen_d = pend_pen_q;
               color_d  = pend_color_q;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!pt_pen_q) begin
               prev_x_d     = pt_x_q;
               prev_y_d     = pt_y_q;
               prev_valid_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               cx_d     = start_x;
               cy_d     = start_y;
               dx_d     = adx;
               dy_d     = -ady;
               sx_neg_d = start_x > pt_x_q;
               sy_neg_d = start_y > pt_y_q;
               err_d    = {1'b0, adx} - {1'b0, ady};
               ox_d     = 3'd0;
               oy_d     = 3'd0;
               state_d  = ST_STAMP;
            end
         end
         ST_STAMP: begin
            if (px >= 0 && px < SCR_W && py >= 0 && py < SCR_H) begin
               vga_x_d     = px[8:0];
               vga_y_d     = py[7:0];
               vga_color_d = color_q;
               vga_write_d = 1'b1;
            end
            if (ox_q == BMAX) begin
               ox_d = 3'd0;
               if (oy_q == BMAX) begin
                  oy_d    = 3'd0;
                  state_d = ST_ADVANCE;
               end else begin
                  oy_d = oy_q + 3'd1;
               end
            end else begin
               ox_d = ox_q + 3'd1;
            end
         end
         ST_ADVANCE: begin
            if (cx_q == pt_x_q && cy_q == pt_y_q) begin
               prev_x_d     = pt_x_q;
               prev_y_d     = pt_y_q;
               prev_valid_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               // both tests use the e2 from before this step
               if (e2 >= dy12) begin
                  err_n = err_n + {dy_q[9], dy_q};
                  cx_d  = sx_neg_q ? cx_q - 9'd1 : cx_q + 9'd1;
               end
               if (e2 <= dx12) begin
                  err_n = err_n + {1'b0, dx_q};
                  cy_d  = sy_neg_q ? cy_q - 8'd1 : cy_q + 8'd1;
               end
               err_d   = err_n;
               ox_d    = 3'd0;
               oy_d    = 3'd0;
               state_d = ST_STAMP;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // a same-cycle strobe refills the slot after the pop
      if (pop) pend_full_d = 1'b0;
      if (bus.cursor_valid) begin
         pend_x_d     = bus.cursor_x;
         pend_y_d     = bus.cursor_y;
         pend_pen_d   = bus.pen_down;
         pend_color_d = bus.pen_color;
         pend_full_d  = 1'b1;
      end
      coalesced_d = bus.cursor_valid && pend_full_q && !pop;
      busy_d      = (state_d != ST_IDLE) || pend_full_d;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pend_x_q     <= '0;
         pend_y_q     <= '0;
         pend_pen_q   <= 1'b0;
         pend_color_q <= '0;
         pend_full_q  <= 1'b0;
         pt_x_q       <= '0;
         pt_y_q       <= '0;
         pt_pen_q     <= 1'b0;
         color_q      <= '0;
         prev_x_q     <= '0;
         prev_y_q     <= '0;
         prev_valid_q <= 1'b0;
         cx_q         <= '0;
         cy_q         <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         sx_neg_q     <= 1'b0;
         sy_neg_q     <= 1'b0;
         err_q        <= '0;
         ox_q         <= '0;
         oy_q         <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_color_q  <= '0;
         vga_write_q  <= 1'b0;
         busy_q       <= 1'b0;
         coalesced_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         pend_pen_q   <= pend_pen_d;
         pend_color_q <= pend_color_d;
         pend_full_q  <= pend_full_d;
         pt_x_q       <= pt_x_d;
         pt_y_q       <= pt_y_d;
         pt_pen_q     <= pt_pen_d;
         color_q      <= color_d;
         prev_x_q     <= prev_x_d;
         prev_y_q     <= prev_y_d;
         prev_valid_q <= prev_valid_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         sx_neg_q     <= sx_neg_d;
         sy_neg_q     <= sy_neg_d;
         err_q        <= err_d;
         ox_q         <= ox_d;
         oy_q         <= oy_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_color_q  <= vga_color_d;
         vga_write_q  <= vga_write_d;
         busy_q       <= busy_d;
         coalesced_q  <= coalesced_d;
      end
   end

   assign bus.vga_x     = vga_x_q;
   assign bus.vga_y     = vga_y_q;
   assign bus.vga_color = vga_color_q;
   assign bus.vga_write = vga_write_q;
   assign bus.busy      = busy_q;
   assign bus.coalesced = coalesced_q;

endmodule

// File: tb/tb_paint_stroke_engine.sv
// tb_paint_stroke_engine
//   Directed bench: dut5 uses a 5x5 brush, dut1 a 1x1 brush (line geometry).
//   Written pixels are collected at the falling edge as {x, y, color}.
module tb_paint_stroke_engine;

`ifdef PAINT_STROKE_INTERP_EN
   localparam bit INTERP = 1'b1;
`else
   localparam bit INTERP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst5 = 1'b1;
   logic rst1 = 1'b1;
   always #10 clk = ~clk;

   paint_stroke_engine_if bus5();
   paint_stroke_engine_if bus1();

   paint_stroke_engine #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240), .BRUSH_SIZE(5)) dut5 (
      .CLOCK_50 (clk),
      .reset    (rst5),
      .bus      (bus5)
   );

   paint_stroke_engine #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240), .BRUSH_SIZE(1)) dut1 (
      .CLOCK_50 (clk),
      .reset    (rst1),
      .bus      (bus1)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [25:0] wq5[$];
   logic [25:0] wq1[$];
   int coal1 = 0;

   always @(negedge clk) begin
      if (bus5.vga_write === 1'b1) wq5.push_back({bus5.vga_x, bus5.vga_y, bus5.vga_color});
      if (bus1.vga_write === 1'b1) wq1.push_back({bus1.vga_x, bus1.vga_y, bus1.vga_color});
      if (bus1.coalesced === 1'b1) coal1++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic int pk(input int x, input int y, input int c);
      return (x << 17) | (y << 9) | c;
   endfunction

   task automatic strobe5(input int x, input int y, input bit pen, input int col);
      bus5.cursor_x     = 9'(x);
      bus5.cursor_y     = 8'(y);
      bus5.pen_down     = pen;
      bus5.pen_color    = 9'(col);
      bus5.cursor_valid = 1'b1;
      @(posedge clk);
      #1 bus5.cursor_valid = 1'b0;
   endtask

   task automatic strobe1(input int x, input int y, input bit pen, input int col);
      bus1.cursor_x     = 9'(x);
      bus1.cursor_y     = 8'(y);
      bus1.pen_down     = pen;
      bus1.pen_color    = 9'(col);
      bus1.cursor_valid = 1'b1;
      @(posedge clk);
      #1 bus1.cursor_valid = 1'b0;
   endtask

   // c = 0 is the falling edge right after the strobe edge
   task automatic run5(output int first_wr, output int busy_cyc);
      bit done = 1'b0;
      first_wr = -1;
      busy_cyc = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (bus5.vga_write && first_wr < 0) first_wr = c;
         if (bus5.busy) busy_cyc++;
         else begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("idle_timeout5", 0, 1);
   endtask

   task automatic run1(output int busy_cyc);
      bit done = 1'b0;
      busy_cyc = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (bus1.busy) busy_cyc++;
         else begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("idle_timeout1", 0, 1);
   endtask

   task automatic reset5();
      rst5 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst5 = 1'b0;
   endtask

   task automatic reset1();
      rst1 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst1 = 1'b0;
   endtask

   initial begin
      int fw, bc, bad, nw;
      int exp_q[$];
      bus5.cursor_x = '0; bus5.cursor_y = '0; bus5.cursor_valid = 1'b0;
      bus5.pen_down = 1'b0; bus5.pen_color = '0;
      bus1.cursor_x = '0; bus1.cursor_y = '0; bus1.cursor_valid = 1'b0;
      bus1.pen_down = 1'b0; bus1.pen_color = '0;
      repeat (3) @(posedge clk);
      #1 begin rst5 = 1'b0; rst1 = 1'b0; end

      // reset state
      @(negedge clk);
      check("rst_vga_x", int'(bus5.vga_x), 0);
      check("rst_vga_y", int'(bus5.vga_y), 0);
      check("rst_vga_color", int'(bus5.vga_color), 0);
      check("rst_vga_write", int'(bus5.vga_write), 0);
      check("rst_busy", int'(bus5.busy), 0);
      check("rst_coalesced", int'(bus5.coalesced), 0);
      check("rst_busy1", int'(bus1.busy), 0);

      // single 5x5 stamp at (100,100)
      wq5.delete();
      strobe5(100, 100, 1'b1, 9'h1A5);
      run5(fw, bc);
      check("stamp_latency", fw, 3);
      check("stamp_cycles", bc, 28);
      check("stamp_count", wq5.size(), 25);
      for (int i = 0; i < 25 && i < wq5.size(); i++)
         check("stamp_px", int'(wq5[i]), pk(98 + i % 5, 98 + i / 5, 9'h1A5));

      // corner clip at (0,0)
      reset5();
      wq5.delete();
      strobe5(0, 0, 1'b1, 9'h0F0);
      run5(fw, bc);
      check("corner_cycles", bc, 28);
      check("corner_count", wq5.size(), 9);
      bad = 0;
      foreach (wq5[i]) if (wq5[i][25:17] > 9'd2 || wq5[i][16:9] > 8'd2) bad++;
      check("corner_bounds", bad, 0);
      if (wq5.size() > 0) begin
         check("corner_first", int'(wq5[0]), pk(0, 0, 9'h0F0));
         check("corner_last", int'(wq5[wq5.size()-1]), pk(2, 2, 9'h0F0));
      end

      // line (10,10) -> (14,12), 1x1 brush; points from the err/e2 stepping
      reset1();
      wq1.delete();
      strobe1(10, 10, 1'b1, 9'h111);
      run1(bc);
      check("line_first_cycles", bc, 4);
      strobe1(14, 12, 1'b1, 9'h111);
      run1(bc);
      check("line_cycles", bc, INTERP ? 12 : 4);
      exp_q.delete();
      exp_q.push_back(pk(10, 10, 9'h111));
      if (INTERP) begin
         exp_q.push_back(pk(10, 10, 9'h111));
         exp_q.push_back(pk(11, 11, 9'h111));
         exp_q.push_back(pk(12, 11, 9'h111));
         exp_q.push_back(pk(13, 12, 9'h111));
      end
      exp_q.push_back(pk(14, 12, 9'h111));
      check("line_count", wq1.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wq1.size(); i++)
         check("line_px", int'(wq1[i]), exp_q[i]);

      // pen up between points
      reset1();
      wq1.delete();
      strobe1(50, 50, 1'b1, 9'h007);
      run1(bc);
      strobe1(60, 50, 1'b0, 9'h007);
      run1(bc);
      strobe1(70, 50, 1'b1, 9'h007);
      run1(bc);
      check("penup_count", wq1.size(), INTERP ? 12 : 2);
      bad = 0;
      foreach (wq1[i]) if (wq1[i][25:17] > 9'd50 && wq1[i][25:17] < 9'd60) bad++;
      check("penup_gap", bad, 0);
      if (wq1.size() > 1) begin
         check("penup_seg_start", int'(wq1[1][25:17]), INTERP ? 60 : 70);
         check("penup_last", int'(wq1[wq1.size()-1]), pk(70, 50, 9'h007));
      end

      // coalescing: four back-to-back strobes; the second lands on the pop
      reset1();
      wq1.delete();
      coal1 = 0;
      strobe1(20, 20, 1'b1, 9'h1C0);
      strobe1(30, 20, 1'b1, 9'h1C0);
      strobe1(40, 20, 1'b1, 9'h1C0);
      strobe1(25, 30, 1'b1, 9'h1C0);
      run1(bc);
      check("coal_pulses", coal1, 2);
      check("coal_count", wq1.size(), INTERP ? 12 : 2);
      bad = 0;
      foreach (wq1[i]) if (wq1[i][25:17] >= 9'd30) bad++;
      check("coal_dropped", bad, 0);
      if (wq1.size() > 0)
         check("coal_last", int'(wq1[wq1.size()-1]), pk(25, 30, 9'h1C0));

      // reset during STAMP
      reset5();
      strobe5(10, 10, 1'b1, 9'h0AA);
      run5(fw, bc);
      strobe5(100, 100, 1'b1, 9'h0AA);
      bad = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus5.vga_write) begin
            bad = 0;
            break;
         end
      end
      check("midrst_saw_write", bad, 0);
      rst5 = 1'b1;
      @(posedge clk);
      #1 rst5 = 1'b0;
      @(negedge clk);
      check("midrst_busy", int'(bus5.busy), 0);
      check("midrst_vga_x", int'(bus5.vga_x), 0);
      nw = int'(bus5.vga_write);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus5.vga_write) nw++;
      end
      check("midrst_writes", nw, 0);
      wq5.delete();
      strobe5(200, 100, 1'b1, 9'h155);
      run5(fw, bc);
      check("midrst_restart_count", wq5.size(), 25);
      if (wq5.size() > 0)
         check("midrst_restart_first", int'(wq5[0]), pk(198, 98, 9'h155));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
